// File: rtl/johnson_mon_pkg.sv
// Purpose: shared types and constants for the Johnson counter phase monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: monitor FSM state enum, default counter width and lock threshold,
// and helpers for the phase-index width and the saturating error counter.

package johnson_mon_pkg;

    // Default Johnson counter width and number of consecutive successor
    // steps needed before the monitor declares lock.
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_LOCK_THRESH = 3;

    // Error counter width; the counter saturates at its all-ones value.
    localparam int ERR_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Bits needed to index the 2*width phases of a width-bit Johnson counter.
    function automatic int pw_of(input int width);
        return (width <= 1) ? 1 : $clog2(2 * width);
    endfunction

    // Bits needed to hold a good-step count from 0 up to thresh inclusive.
    function automatic int gw_of(input int thresh);
        return (thresh <= 1) ? 1 : $clog2(thresh + 1);
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Purpose: decode a Johnson counter pattern into its phase index.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input pattern.
//
// Ports:
//   jc    - WIDTH-bit Johnson counter pattern
//   phase - phase index 0..2*WIDTH-1 (0 when the pattern is illegal)
//   legal - 1 when jc is one of the 2*WIDTH legal Johnson states
//
// Phase k for k <= WIDTH is k ones packed at the LSB end; for k > WIDTH it
// is (2*WIDTH-k) ones packed at the MSB end, i.e. bits k-WIDTH..WIDTH-1 set.

module johnson_decode
    import johnson_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]         jc,
    output logic [pw_of(WIDTH)-1:0]  phase,
    output logic                     legal
);

    localparam int PW  = pw_of(WIDTH);
    localparam int NPH = 2 * WIDTH;

    logic [WIDTH-1:0] pat;

    // Compare against every legal pattern; at most one can match since the
    // 2*WIDTH Johnson states are distinct.
    always_comb begin
        phase = '0;
        legal = 1'b0;
        pat   = '0;
        for (int k = 0; k < NPH; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                pat[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
            end
            if (jc == pat) begin
                legal = 1'b1;
                phase = PW'(k);
            end
        end
    end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Purpose: track an upstream Johnson counter, report phase, lock and errors.
// Latency: 2 clk edges from jc_in to phase and all flags.
// Backpressure: none; one sample is consumed every clock.
//
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous active-high reset
//   jc_in       - Johnson counter value from the upstream counter
//   phase       - decoded phase index, holds last legal value on bad input
//   phase_valid - phase reflects a legal decode of the current sample
//   locked      - monitor is in the LOCKED state
//   illegal     - one-cycle pulse: sample was not a Johnson pattern
//   seq_err     - one-cycle pulse: legal sample that was neither hold nor successor
//   wrap        - one-cycle pulse: locked successor step from last phase to 0
//   err_count   - saturating count of errors seen while locked

module johnson_phase_monitor
    import johnson_mon_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LOCK_THRESH = DEF_LOCK_THRESH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         jc_in,
    output logic [pw_of(WIDTH)-1:0]  phase,
    output logic                     phase_valid,
    output logic                     locked,
    output logic                     illegal,
    output logic                     seq_err,
    output logic                     wrap,
    output logic [ERR_W-1:0]         err_count
);

    localparam int PW  = pw_of(WIDTH);
    localparam int GW  = gw_of(LOCK_THRESH);
    localparam int NPH = 2 * WIDTH;

    localparam logic [PW-1:0] LAST_PH = PW'(NPH - 1);
    localparam logic [GW-1:0] THRESH  = GW'(LOCK_THRESH);

    // Input sample register and its decode.
    logic [WIDTH-1:0] jc_q;
    logic [PW-1:0]    dec_phase;
    logic             dec_legal;

    // FSM state and its next-state values.
    state_t           state, state_n;
    logic [GW-1:0]    gcnt, gcnt_n;
    logic [PW-1:0]    prev, prev_n;

    // Step classification against the previously stored phase.
    logic [PW-1:0]    prev_inc;
    logic [GW-1:0]    gcnt_inc;
    logic             is_succ;
    logic             is_hold;

    // Next values of the pulse outputs.
    logic             illegal_n;
    logic             seq_err_n;
    logic             wrap_n;
    logic             err_inc;

    johnson_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .jc    (jc_q),
        .phase (dec_phase),
        .legal (dec_legal)
    );

    // Explicit wrap so non-power-of-two phase counts step correctly.
    assign prev_inc = (prev == LAST_PH) ? '0 : prev + PW'(1);
    assign gcnt_inc = gcnt + GW'(1);
    assign is_succ  = dec_legal && (dec_phase == prev_inc);
    assign is_hold  = dec_legal && (dec_phase == prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gcnt  <= '0;
            prev  <= '0;
        end else begin
            state <= state_n;
            gcnt  <= gcnt_n;
            prev  <= prev_n;
        end
    end

    // prev follows every legal sample, jumps included, so a jump becomes the
    // reference point for the next successor check.
    always_comb begin
        state_n   = state;
        gcnt_n    = gcnt;
        prev_n    = dec_legal ? dec_phase : prev;
        illegal_n = 1'b0;
        seq_err_n = 1'b0;
        wrap_n    = 1'b0;
        err_inc   = 1'b0;

        case (state)
            IDLE: begin
                if (dec_legal) begin
                    state_n = ACQUIRE;
                    gcnt_n  = '0;
                end else begin
                    illegal_n = 1'b1;
                end
            end

            ACQUIRE: begin
                if (!dec_legal) begin
                    state_n   = IDLE;
                    gcnt_n    = '0;
                    illegal_n = 1'b1;
                end else if (is_succ) begin
                    gcnt_n = gcnt_inc;
                    if (gcnt_inc == THRESH) begin
                        state_n = LOCKED;
                    end
                end else if (!is_hold) begin
                    gcnt_n    = '0;
                    seq_err_n = 1'b1;
                end
            end

            LOCKED: begin
                if (!dec_legal) begin
                    state_n   = IDLE;
                    gcnt_n    = '0;
                    illegal_n = 1'b1;
                    err_inc   = 1'b1;
                end else if (is_succ) begin
                    wrap_n = (prev == LAST_PH);
                end else if (!is_hold) begin
                    state_n   = ACQUIRE;
                    gcnt_n    = '0;
                    seq_err_n = 1'b1;
                    err_inc   = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                gcnt_n  = '0;
            end
        endcase
    end

    // Output registers; locked is taken from state_n so it changes on the
    // same edge as the state register and always equals (state == LOCKED).
    always_ff @(posedge clk) begin
        if (rst) begin
            jc_q        <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            wrap        <= 1'b0;
            err_count   <= '0;
        end else begin
            jc_q        <= jc_in;
            if (dec_legal) begin
                phase <= dec_phase;
            end
            phase_valid <= dec_legal;
            locked      <= (state_n == LOCKED);
            illegal     <= illegal_n;
            seq_err     <= seq_err_n;
            wrap        <= wrap_n;
            if (err_inc) begin
                err_count <= sat_inc(err_count);
            end
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Purpose: directed self-checking bench for johnson_phase_monitor.
// Latency: outputs checked 1 ns after each rising edge.
// Backpressure: n/a.

module tb_johnson_phase_monitor;

    logic       clk;
    logic       rst;
    logic [7:0] jc_in;
    logic [3:0] phase;
    logic       phase_valid;
    logic       locked;
    logic       illegal;
    logic       seq_err;
    logic       wrap;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    johnson_phase_monitor #(
        .WIDTH       (8),
        .LOCK_THRESH (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jc_in       (jc_in),
        .phase       (phase),
        .phase_valid (phase_valid),
        .locked      (locked),
        .illegal     (illegal),
        .seq_err     (seq_err),
        .wrap        (wrap),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] jc;
        logic [3:0] ph;
        logic       pv;
        logic       lk;
        logic       il;
        logic       se;
        logic       wr;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[39];

    function automatic vec_t mk(input logic [7:0] jc, input logic [3:0] ph,
                                input logic pv, input logic lk, input logic il,
                                input logic se, input logic wr, input logic [7:0] ec);
        vec_t v;
        v.jc = jc; v.ph = ph; v.pv = pv; v.lk = lk;
        v.il = il; v.se = se; v.wr = wr; v.ec = ec;
        return v;
    endfunction

    // Drive one sample and advance past the next rising edge.
    task automatic step(input logic [7:0] v);
        jc_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] e_ph, input logic e_pv,
                         input logic e_lk, input logic e_il, input logic e_se,
                         input logic e_wr, input logic [7:0] e_ec);
        n_tests++;
        if ({phase, phase_valid, locked, illegal, seq_err, wrap, err_count} !==
            {e_ph, e_pv, e_lk, e_il, e_se, e_wr, e_ec}) begin
            n_fail++;
            $display("FAIL %s: got ph=%0d pv=%0b lk=%0b il=%0b se=%0b wr=%0b ec=%0d, want ph=%0d pv=%0b lk=%0b il=%0b se=%0b wr=%0b ec=%0d",
                     name, phase, phase_valid, locked, illegal, seq_err, wrap, err_count,
                     e_ph, e_pv, e_lk, e_il, e_se, e_wr, e_ec);
        end
    endtask

    initial begin
        logic [7:0] cnt;
        int         wraps;
        logic [7:0] exp_ec;

        // Each row: sample driven this cycle, outputs expected after the edge
        // (which reflect the sample driven one row earlier; row 0 sees the
        // reset value 0x00 of the input register).
        tbl[0]  = mk(8'h00, 4'd0,  1, 0, 0, 0, 0, 8'd0);
        tbl[1]  = mk(8'h01, 4'd0,  1, 0, 0, 0, 0, 8'd0);
        tbl[2]  = mk(8'h03, 4'd1,  1, 0, 0, 0, 0, 8'd0);
        tbl[3]  = mk(8'h07, 4'd2,  1, 0, 0, 0, 0, 8'd0);
        tbl[4]  = mk(8'h0F, 4'd3,  1, 1, 0, 0, 0, 8'd0);
        tbl[5]  = mk(8'h0F, 4'd4,  1, 1, 0, 0, 0, 8'd0);
        tbl[6]  = mk(8'h05, 4'd4,  1, 1, 0, 0, 0, 8'd0);
        tbl[7]  = mk(8'h1F, 4'd4,  0, 0, 1, 0, 0, 8'd1);
        tbl[8]  = mk(8'h3F, 4'd5,  1, 0, 0, 0, 0, 8'd1);
        tbl[9]  = mk(8'h7F, 4'd6,  1, 0, 0, 0, 0, 8'd1);
        tbl[10] = mk(8'hFF, 4'd7,  1, 0, 0, 0, 0, 8'd1);
        tbl[11] = mk(8'hFE, 4'd8,  1, 1, 0, 0, 0, 8'd1);
        tbl[12] = mk(8'hFC, 4'd9,  1, 1, 0, 0, 0, 8'd1);
        tbl[13] = mk(8'hF8, 4'd10, 1, 1, 0, 0, 0, 8'd1);
        tbl[14] = mk(8'hF0, 4'd11, 1, 1, 0, 0, 0, 8'd1);
        tbl[15] = mk(8'hE0, 4'd12, 1, 1, 0, 0, 0, 8'd1);
        tbl[16] = mk(8'hC0, 4'd13, 1, 1, 0, 0, 0, 8'd1);
        tbl[17] = mk(8'h80, 4'd14, 1, 1, 0, 0, 0, 8'd1);
        tbl[18] = mk(8'h00, 4'd15, 1, 1, 0, 0, 0, 8'd1);
        tbl[19] = mk(8'h01, 4'd0,  1, 1, 0, 0, 1, 8'd1);
        tbl[20] = mk(8'h03, 4'd1,  1, 1, 0, 0, 0, 8'd1);
        tbl[21] = mk(8'h07, 4'd2,  1, 1, 0, 0, 0, 8'd1);
        tbl[22] = mk(8'h3F, 4'd3,  1, 1, 0, 0, 0, 8'd1);
        tbl[23] = mk(8'h7F, 4'd6,  1, 0, 0, 1, 0, 8'd2);
        tbl[24] = mk(8'hFF, 4'd7,  1, 0, 0, 0, 0, 8'd2);
        tbl[25] = mk(8'h01, 4'd8,  1, 0, 0, 0, 0, 8'd2);
        tbl[26] = mk(8'h03, 4'd1,  1, 0, 0, 1, 0, 8'd2);
        tbl[27] = mk(8'h07, 4'd2,  1, 0, 0, 0, 0, 8'd2);
        tbl[28] = mk(8'h0F, 4'd3,  1, 0, 0, 0, 0, 8'd2);
        tbl[29] = mk(8'h1F, 4'd4,  1, 1, 0, 0, 0, 8'd2);
        tbl[30] = mk(8'h1F, 4'd5,  1, 1, 0, 0, 0, 8'd2);
        tbl[31] = mk(8'h1F, 4'd5,  1, 1, 0, 0, 0, 8'd2);
        tbl[32] = mk(8'hAA, 4'd5,  1, 1, 0, 0, 0, 8'd2);
        tbl[33] = mk(8'hAA, 4'd5,  0, 0, 1, 0, 0, 8'd3);
        tbl[34] = mk(8'h0F, 4'd5,  0, 0, 1, 0, 0, 8'd3);
        tbl[35] = mk(8'h1F, 4'd4,  1, 0, 0, 0, 0, 8'd3);
        tbl[36] = mk(8'h81, 4'd5,  1, 0, 0, 0, 0, 8'd3);
        tbl[37] = mk(8'h00, 4'd5,  0, 0, 1, 0, 0, 8'd3);
        tbl[38] = mk(8'h00, 4'd0,  1, 0, 0, 0, 0, 8'd3);

        // Reset state.
        rst   = 1'b1;
        jc_in = 8'h00;
        step(8'h00);
        step(8'h00);
        check("reset", 4'd0, 0, 0, 0, 0, 0, 8'd0);
        rst = 1'b0;

        // Directed table: acquire, lock, illegal, relock, wrap, jumps.
        for (int i = 0; i < 39; i++) begin
            step(tbl[i].jc);
            check($sformatf("tbl[%0d]", i), tbl[i].ph, tbl[i].pv, tbl[i].lk,
                  tbl[i].il, tbl[i].se, tbl[i].wr, tbl[i].ec);
        end

        // Free-running counter released from reset together with the monitor.
        rst = 1'b1;
        step(8'h00);
        rst   = 1'b0;
        cnt   = 8'h00;
        wraps = 0;
        for (int t = 0; t <= 36; t++) begin
            step(cnt);
            check($sformatf("run[%0d]", t), (t == 0) ? 4'd0 : 4'((t - 1) % 16), 1,
                  (t >= 4), 0, 0, (t >= 17 && (t - 1) % 16 == 0), 8'd0);
            if (wrap) wraps++;
            cnt = {cnt[6:0], ~cnt[7]};
        end
        n_tests++;
        if (wraps != 2) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d, want 2", wraps);
        end

        // Hold at 0x0F while locked: no pulses, lock retained.
        for (int h = 0; h < 10; h++) begin
            step(8'h0F);
            check($sformatf("hold[%0d]", h), 4'd4, 1, 1, 0, 0, 0, 8'd0);
        end

        // Repeated lock/illegal cycles drive err_count into saturation.
        rst = 1'b1;
        step(8'h00);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(8'h01);
            if (i >= 1 && (i <= 2 || (i >= 253 && i <= 256) || i == 299)) begin
                exp_ec = (i > 255) ? 8'd255 : 8'(i);
                check($sformatf("sat[%0d]", i), 4'd4, 0, 0, 1, 0, 0, exp_ec);
            end
            step(8'h03);
            step(8'h07);
            step(8'h0F);
            step(8'h05);
            if (i == 1) check("sat_locked", 4'd4, 1, 1, 0, 0, 0, 8'd1);
        end
        step(8'h01);
        check("sat_final", 4'd4, 0, 0, 1, 0, 0, 8'd255);

        // Relock, then reset mid-lock and reacquire from IDLE.
        step(8'h03);
        step(8'h07);
        step(8'h0F);
        step(8'h1F);
        check("relock", 4'd4, 1, 1, 0, 0, 0, 8'd255);
        rst = 1'b1;
        step(8'h3F);
        check("midlock_rst", 4'd0, 0, 0, 0, 0, 0, 8'd0);
        rst = 1'b0;
        step(8'h01);
        check("reacq0", 4'd0, 1, 0, 0, 0, 0, 8'd0);
        step(8'h03);
        step(8'h07);
        check("reacq2", 4'd2, 1, 0, 0, 0, 0, 8'd0);
        step(8'h0F);
        check("reacq3", 4'd3, 1, 1, 0, 0, 0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
